sdram_refresh_seq: RTL and testbench

SDRAM_REFRESH_SEQ -- requirements
Module: sdram_refresh_seq

---
 rtl/sdram_refresh_seq.sv | 168 ++++++++++++++++
 tb/tb_sdram_refresh_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_refresh_seq.sv
// SDRAM power-up initialisation and periodic auto-refresh sequencer.
// Borrows the command pins from the access engine via a req/grant handshake.
module sdram_refresh_seq #(
    parameter int unsigned INIT_WAIT_CYCLES = 5000,
    parameter int unsigned REFRESH_CYCLES   = 390,
    parameter int unsigned TRP              = 2,
    parameter int unsigned TRFC             = 7,
    parameter int unsigned TMRD             = 2,
    parameter logic [12:0] MODE_REG         = 13'h0032
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        ref_gnt_i,
    output logic        ref_req_o,
    output logic        seq_own_o,
    output logic        init_done_o,
    output logic        ref_ovf_o,
    output logic        cs_n_o,
    output logic        ras_n_o,
    output logic        cas_n_o,
    output logic        we_n_o,
    output logic [12:0] a_o,
    output logic [1:0]  ba_o,
    output logic        cke_o
);

    localparam int unsigned TA   = (TRP > TRFC) ? TRP : TRFC;
    localparam int unsigned TB   = (TA > TMRD) ? TA : TMRD;
    localparam int unsigned TMax = (TB > INIT_WAIT_CYCLES) ? TB : INIT_WAIT_CYCLES;
    localparam int unsigned TW   = $clog2(TMax + 1);
    localparam int unsigned RW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [TW-1:0] InitLoad = TW'(INIT_WAIT_CYCLES - 1);
    localparam logic [TW-1:0] TrpLoad  = TW'(TRP - 1);
    localparam logic [TW-1:0] TrfcLoad = TW'(TRFC - 1);
    localparam logic [TW-1:0] TmrdLoad = TW'(TMRD - 1);
    localparam logic [RW-1:0] RefLoad  = RW'(REFRESH_CYCLES - 1);

    localparam logic [3:0]  CmdNop  = 4'b0111;
    localparam logic [3:0]  CmdPre  = 4'b0010;
    localparam logic [3:0]  CmdRef  = 4'b0001;
    localparam logic [3:0]  CmdLmr  = 4'b0000;
    localparam logic [12:0] AddrAll = 13'h0400;

    typedef enum logic [3:0] {
        StInitWait,
        StInitPre,
        StInitRef1,
        StInitRef2,
        StInitLmr,
        StIdle,
        StReq,
        StPre,
        StRef
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [12:0]   addr_q, addr_d;
    logic          init_done_q, init_done_d;
    logic          cke_q;
    logic          ovf_q, ovf_d;
    logic [2:0]    pend_q, pend_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          tick;
    logic          ref_cmd;

    // Commands are registered: cmd_d is the command for the state being entered.
    always_comb begin
        state_d     = state_q;
        timer_d     = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
        cmd_d       = CmdNop;
        addr_d      = '0;
        init_done_d = init_done_q;
        case (state_q)
            StInitWait: if (timer_q == '0) begin
                state_d = StInitPre;
                timer_d = TrpLoad;
                cmd_d   = CmdPre;
                addr_d  = AddrAll;
            end
            StInitPre: if (timer_q == '0) begin
                state_d = StInitRef1;
                timer_d = TrfcLoad;
                cmd_d   = CmdRef;
            end
            StInitRef1: if (timer_q == '0) begin
                state_d = StInitRef2;
                timer_d = TrfcLoad;
                cmd_d   = CmdRef;
            end
            StInitRef2: if (timer_q == '0) begin
                state_d = StInitLmr;
                timer_d = TmrdLoad;
                cmd_d   = CmdLmr;
                addr_d  = MODE_REG;
            end
            StInitLmr: if (timer_q == '0) begin
                state_d     = StIdle;
                init_done_d = 1'b1;
            end
            StIdle: if (pend_q != 3'd0) state_d = StReq;
            StReq: if (ref_gnt_i) begin
                state_d = StPre;
                timer_d = TrpLoad;
                cmd_d   = CmdPre;
                addr_d  = AddrAll;
            end
            StPre: if (timer_q == '0) begin
                state_d = StRef;
                timer_d = TrfcLoad;
                cmd_d   = CmdRef;
            end
            StRef: if (timer_q == '0) state_d = StIdle;
            default: state_d = StInitWait;
        endcase
    end

    // Periodic tick bookkeeping; a tick landing on the refresh command cancels out.
    always_comb begin
        tick    = init_done_q && (rcnt_q == '0);
        ref_cmd = (state_q == StRef) && (cmd_q == CmdRef);
        rcnt_d  = rcnt_q;
        if (init_done_q) rcnt_d = tick ? RefLoad : rcnt_q - 1'b1;
        pend_d = pend_q;
        case ({tick, ref_cmd})
            2'b10:   if (pend_q != 3'd7) pend_d = pend_q + 3'd1;
            2'b01:   if (pend_q != 3'd0) pend_d = pend_q - 3'd1;
            default: pend_d = pend_q;
        endcase
        ovf_d = ovf_q | (tick && (pend_q == 3'd7));
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StInitWait;
            timer_q     <= InitLoad;
            cmd_q       <= CmdNop;
            addr_q      <= '0;
            init_done_q <= 1'b0;
            cke_q       <= 1'b0;
            ovf_q       <= 1'b0;
            pend_q      <= 3'd0;
            rcnt_q      <= RefLoad;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            init_done_q <= init_done_d;
            cke_q       <= 1'b1;
            ovf_q       <= ovf_d;
            pend_q      <= pend_d;
            rcnt_q      <= rcnt_d;
        end
    end

    assign {cs_n_o, ras_n_o, cas_n_o, we_n_o} = cmd_q;
    assign a_o         = addr_q;
    assign ba_o        = 2'b00;
    assign cke_o       = cke_q;
    assign init_done_o = init_done_q;
    assign ref_ovf_o   = ovf_q;
    assign ref_req_o   = (state_q == StReq);
    assign seq_own_o   = !((state_q == StIdle) || (state_q == StReq));

endmodule

// File: tb/tb_sdram_refresh_seq.sv
// Bench for sdram_refresh_seq: directed timeline, expected commands queued
// by the stimulus and matched by an independent command monitor.
module tb_sdram_refresh_seq;

    localparam logic [3:0] Nop = 4'b0111;
    localparam logic [3:0] Pre = 4'b0010;
    localparam logic [3:0] Ref = 4'b0001;
    localparam logic [3:0] Lmr = 4'b0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        gnt;
    logic        ref_req, seq_own, init_done, ref_ovf;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [12:0] a;
    logic [1:0]  ba;
    logic        cke;

    sdram_refresh_seq #(
        .INIT_WAIT_CYCLES (10),
        .REFRESH_CYCLES   (20),
        .TRP              (2),
        .TRFC             (4),
        .TMRD             (2)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .ref_gnt_i   (gnt),
        .ref_req_o   (ref_req),
        .seq_own_o   (seq_own),
        .init_done_o (init_done),
        .ref_ovf_o   (ref_ovf),
        .cs_n_o      (cs_n),
        .ras_n_o     (ras_n),
        .cas_n_o     (cas_n),
        .we_n_o      (we_n),
        .a_o         (a),
        .ba_o        (ba),
        .cke_o       (cke)
    );

    always #5 clk = ~clk;

    int cyc  = 0;
    int base = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [12:0] a;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [3:0] mon_cmd;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic expect_cmd(input int off, input logic [3:0] cmd, input logic [12:0] addr);
        exp_t e;
        e.cyc = base + off;
        e.cmd = cmd;
        e.a   = addr;
        exp_q.push_back(e);
    endtask

    task automatic expect_init();
        expect_cmd(10, Pre, 13'h0400);
        expect_cmd(12, Ref, 13'h0000);
        expect_cmd(16, Ref, 13'h0000);
        expect_cmd(20, Lmr, 13'h0032);
    endtask

    task automatic at(input int off);
        while (cyc < base + off) @(negedge clk);
    endtask

    task automatic check(input string name, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d (rel %0d): got %b, want %b",
                     name, cyc, cyc - base, act, req);
        end
    endtask

    // Command monitor: every non-NOP cycle must match the head of the queue.
    always @(negedge clk) begin
        mon_cmd = {cs_n, ras_n, cas_n, we_n};
        n_tests++;
        if (mon_cmd === Nop) begin
            if (a !== 13'h0 || ba !== 2'b00) begin
                n_fail++;
                $display("FAIL nop_addr at cycle %0d: got a=%h ba=%b, want 0", cyc, a, ba);
            end
        end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_cmd at cycle %0d: got cmd=%b a=%h, want none",
                     cyc, mon_cmd, a);
        end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc != cyc || mon_e.cmd !== mon_cmd || mon_e.a !== a || ba !== 2'b00) begin
                n_fail++;
                $display("FAIL cmd at cycle %0d: got cmd=%b a=%h ba=%b, want cmd=%b a=%h at cycle %0d",
                         cyc, mon_cmd, a, ba, mon_e.cmd, mon_e.a, mon_e.cyc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        gnt = 1'b1;
        @(negedge clk);
        at(2);
        check("rst_cke", cke, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_seq_own", seq_own, 1'b1);
        check("rst_ref_req", ref_req, 1'b0);
        check("rst_ovf", ref_ovf, 1'b0);
        at(3);
        rst  = 1'b0;
        base = cyc;
        expect_init();

        // Power-up sequence
        at(1);  check("cke_on", cke, 1'b1);
        at(21); check("init_done_21", init_done, 1'b0); check("own_21", seq_own, 1'b1);
        at(22); check("init_done_22", init_done, 1'b1); check("own_22", seq_own, 1'b0);
        check("req_22", ref_req, 1'b0);

        // First refresh with grant held
        expect_cmd(44, Pre, 13'h0400);
        expect_cmd(46, Ref, 13'h0000);
        at(42); check("req_42", ref_req, 1'b0);
        at(43); check("req_43", ref_req, 1'b1); check("own_43", seq_own, 1'b0);
        at(44); check("own_44", seq_own, 1'b1); check("req_44", ref_req, 1'b0);
        at(49); check("own_49", seq_own, 1'b1);
        at(50); check("own_50", seq_own, 1'b0); check("req_50", ref_req, 1'b0);
        gnt = 1'b0;

        // Deferred refreshes: three pending, run back-to-back on grant
        at(63);  check("defer_req_63", ref_req, 1'b1);
        at(90);  check("defer_req_90", ref_req, 1'b1);
        at(110); check("defer_req_110", ref_req, 1'b1); check("defer_own_110", seq_own, 1'b0);
        expect_cmd(112, Pre, 13'h0400);
        expect_cmd(114, Ref, 13'h0000);
        expect_cmd(120, Pre, 13'h0400);
        expect_cmd(122, Ref, 13'h0000);
        expect_cmd(128, Pre, 13'h0400);
        expect_cmd(130, Ref, 13'h0000);
        at(111); gnt = 1'b1;
        at(112); check("own_112", seq_own, 1'b1);
        at(118); check("idle_req_118", ref_req, 1'b0); check("idle_own_118", seq_own, 1'b0);
        at(119); check("req_119", ref_req, 1'b1);
        at(126); check("idle_req_126", ref_req, 1'b0); check("idle_own_126", seq_own, 1'b0);
        at(127); check("req_127", ref_req, 1'b1);
        at(128); gnt = 1'b0;
        at(134); check("idle_req_134", ref_req, 1'b0);
        at(135); check("req_135", ref_req, 1'b1);

        // Overflow: pending saturates at 7, eighth tick sets the sticky flag
        at(241); check("ovf_241", ref_ovf, 1'b0);
        at(261); check("ovf_261", ref_ovf, 1'b0);
        at(262); check("ovf_262", ref_ovf, 1'b1);
        at(300); check("req_300", ref_req, 1'b1); check("ovf_300", ref_ovf, 1'b1);
        expect_cmd(336, Pre, 13'h0400);
        expect_cmd(338, Ref, 13'h0000);
        at(335); gnt = 1'b1;
        at(336); check("ovf_336", ref_ovf, 1'b1);
        at(339); check("ovf_339", ref_ovf, 1'b1); check("own_339", seq_own, 1'b1);

        // Reset pulse inside the TRFC wait
        at(340); rst = 1'b1;
        at(341);
        check("rr_init_done", init_done, 1'b0);
        check("rr_cke", cke, 1'b0);
        check("rr_ovf", ref_ovf, 1'b0);
        check("rr_own", seq_own, 1'b1);
        check("rr_req", ref_req, 1'b0);
        rst  = 1'b0;
        base = cyc;
        expect_init();
        at(1);  check("rr_cke_on", cke, 1'b1); gnt = 1'b0;
        at(21); check("rr_init_done_21", init_done, 1'b0);
        at(22); check("rr_init_done_22", init_done, 1'b1); check("rr_own_22", seq_own, 1'b0);

        // Tick coinciding with AUTO_REFRESH at relative cycle 61
        expect_cmd(59, Pre, 13'h0400);
        expect_cmd(61, Ref, 13'h0000);
        expect_cmd(67, Pre, 13'h0400);
        expect_cmd(69, Ref, 13'h0000);
        expect_cmd(84, Pre, 13'h0400);
        expect_cmd(86, Ref, 13'h0000);
        at(43); check("tk_req_43", ref_req, 1'b1);
        at(58); check("tk_req_58", ref_req, 1'b1); gnt = 1'b1;
        at(65); check("tk_idle_req_65", ref_req, 1'b0); check("tk_idle_own_65", seq_own, 1'b0);
        at(66); check("tk_req_66", ref_req, 1'b1);
        at(73); check("tk_req_73", ref_req, 1'b0);
        at(80); check("tk_req_80", ref_req, 1'b0);
        at(83); check("tk_req_83", ref_req, 1'b1);
        at(95);

        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_cmd: got nothing, want cmd=%b a=%h at cycle %0d",
                     mon_e.cmd, mon_e.a, mon_e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
